seq_digit_blinker: RTL and testbench
====================================

# seq_digit_blinker

Downstream consumer of the sequence generator's current number. It accepts one 16-bit value per valid/ready handshake and converts it to decimal with a sequential double-dabble. It then "blinks out" each decimal digit on a single LED as a count of short pulses, most-significant non-zero digit first. A human can read Fibonacci, prime, square or triangular values off the board LED.

## Interface
Parameters:
- `TICK_DIV`, default 1_000_000: clk cycles per time unit; minimum 1.
- `ON_UNITS`, default 1: LED-on length of one count pulse, in units.
- `OFF_UNITS`, default 1: LED-off length after each pulse, in units.
- `ZERO_UNITS`, default 3: LED-on length of the single long pulse for digit 0.
- `DIGIT_GAP`, default 3: extra off units after the last pulse of a digit.
- `WORD_GAP`, default 7: extra off units after the last digit, before returning to idle.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  when 0, all state and counters hold.
- `in_valid`  in  1  `in_value` is offered.
- `in_ready`  out  1  block can accept a value; high only in IDLE.
- `in_value`  in  16  unsigned number to display.
- `led`  out  1  blink output; registered.
- `busy`  out  1  high in every state except IDLE.
- `digit_out`  out  4  BCD digit currently being blinked; 0 in IDLE.
- `digit_strobe`  out  1  one-cycle pulse on the first cycle of each digit's first pulse.

## Operation
- FSM states: IDLE, CONVERT, PULSE_ON, PULSE_OFF, GAP_DIGIT, GAP_WORD.
- IDLE: `in_ready`=1. A transfer happens when `in_valid && in_ready && ena` at a clock edge.
  - On a transfer: latch `in_value`, clear the 20-bit BCD register, and go to CONVERT.
  - `in_value` is ignored at all other times. No queuing.
- CONVERT: 16 shift/add-3 iterations, one per enabled cycle, giving 5 BCD digits.
  - After that, one cycle to select the start digit: the most-significant non-zero digit, or digit 0 if the value is 0.
  - Then go to PULSE_ON.
- PULSE_ON: `led`=1.
  - Duration is `ON_UNITS`×`TICK_DIV` cycles for digits 1–9.
  - Duration is `ZERO_UNITS`×`TICK_DIV` cycles for digit 0.
- PULSE_OFF: `led`=0 for `OFF_UNITS`×`TICK_DIV` cycles. Then:
  - return to PULSE_ON if pulses remain for this digit (a digit d>0 has d pulses; digit 0 has one);
  - otherwise go to GAP_DIGIT if more digits remain;
  - otherwise go to GAP_WORD.
- GAP_DIGIT: `led`=0 for `DIGIT_GAP`×`TICK_DIV` cycles, then advance to the next lower digit and go to PULSE_ON.
- GAP_WORD: `led`=0 for `WORD_GAP`×`TICK_DIV` cycles, then go to IDLE.
- Internal zero digits, e.g. the 0 in 305, are blinked as long pulses. Leading zeros are never blinked.
- Phase timer: a 32-bit down-counter, loaded on entry to each timed state and decremented on each enabled cycle; the state exits when it reaches 1.
  - Unit products are computed at 32-bit width.
  - A product of 0 is treated as 1 cycle.
- `ena`=0 freezes the FSM, the timer, `led` and the handshake. While `ena`=0, `in_ready` is still driven from the state, but no transfer occurs.
- Reset (any time, including mid-blink): state=IDLE, `led`=0, `busy`=0, `in_ready`=1, `digit_out`=0, `digit_strobe`=0, all counters cleared.

## Timing
- Let edge 0 be the transfer edge.
- CONVERT occupies edges 1–16; the start digit is selected at edge 17; `led` rises after edge 18.
- Latency from transfer to the first `led` high: 18 cycles, with `ena` held at 1.
- `in_ready` drops after edge 0 and rises after the edge that leaves GAP_WORD.
- The next transfer can occur on that same cycle; there are no dead cycles in IDLE.
- `digit_out` updates on the same edge as the entry into that digit's first PULSE_ON. `digit_strobe` is high for exactly that cycle.
- Total display time for value v, in units:
  - sum over displayed digits of the pulse times: d×(`ON_UNITS`+`OFF_UNITS`) for d>0, or `ZERO_UNITS`+`OFF_UNITS` for d=0;
  - plus `DIGIT_GAP`×(number of digits − 1);
  - plus `WORD_GAP`.

## Structure
- Package `seq_blink_pkg`:
  - state enum;
  - default unit constants;
  - `BCD_DIGITS`=5;
  - `VALUE_W`=16.
- Sub-module `bin2bcd_seq`:
  - start/done handshake;
  - 16-cycle double-dabble;
  - 16-bit in, 20-bit BCD out.
- Top-level: FSM, phase timer, digit pointer, pulse counter.

## Test plan
All scenarios use `TICK_DIV`=4 and default units.
- Reset mid-PULSE_ON of value 7 -> `led`=0, `busy`=0 and `in_ready`=1 immediately. The next transfer of 2 gives exactly 2 pulses.
- Value 0 -> one `led` high of 12 cycles, `digit_out`=0, then 4+28 off cycles and back to IDLE. `busy` lasts 18+12+4+28 cycles in total.
- Value 305 -> pulse groups of 3, 1 long, and 5. `digit_strobe` fires 3 times with `digit_out` sequence 3, 0, 5. Each digit gap is 16 off cycles (4+12).
- Value 65535 -> 24 `led` pulses, grouped 6, 5, 5, 3, 5.
- `in_valid` held high with values 12 then 13 -> 12 is blinked (1 pulse, gap, 2 pulses). 13 is accepted only on the first IDLE cycle, with no transfer while `busy`.
- Toggle `ena` low for 50 cycles mid-pulse -> `led` and the timer freeze. The total display time is extended by exactly 50 cycles.

Source files
------------

// File: rtl/seq_blink_pkg.sv
// Shared types and constants for the decimal digit blinker.
// States, default unit timings, BCD sizing and small BCD helpers.
package seq_blink_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    PULSE_ON  = 3'd2,
    PULSE_OFF = 3'd3,
    GAP_DIGIT = 3'd4,
    GAP_WORD  = 3'd5
  } blink_state_t;

  localparam int unsigned DEF_TICK_DIV   = 1_000_000;
  localparam int unsigned DEF_ON_UNITS   = 1;
  localparam int unsigned DEF_OFF_UNITS  = 1;
  localparam int unsigned DEF_ZERO_UNITS = 3;
  localparam int unsigned DEF_DIGIT_GAP  = 3;
  localparam int unsigned DEF_WORD_GAP   = 7;

  localparam int unsigned VALUE_W    = 16;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  // Phase length in cycles; products wrap at 32 bits and a zero length means one cycle.
  function automatic logic [31:0] unit_cycles(input int unsigned units, input int unsigned tick);
    logic [31:0] p;
    p = units * tick;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

  function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd, input logic [2:0] idx);
    return bcd[4*idx +: 4];
  endfunction

  function automatic logic [2:0] msd_index(input logic [BCD_W-1:0] bcd);
    logic [2:0] m;
    m = '0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) m = 3'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5-digit BCD, one bit per enabled cycle.
// done pulses for one enabled cycle after the last shift.
module bin2bcd_seq
  import seq_blink_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  logic [VALUE_W-1:0] bin_q;
  logic [4:0]         cnt_q;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      cnt_q <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (start) begin
        bin_q <= value;
        bcd   <= '0;
        cnt_q <= 5'(VALUE_W);
      end else if (cnt_q != 5'd0) begin
        bcd   <= {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q - 5'd1;
        done  <= (cnt_q == 5'd1);
      end
    end
  end

endmodule

// File: rtl/seq_digit_blinker.sv
// Accepts a 16-bit value and blinks its decimal digits on one LED,
// most-significant non-zero digit first; digit 0 is one long pulse.
module seq_digit_blinker
  import seq_blink_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned ON_UNITS   = DEF_ON_UNITS,
  parameter int unsigned OFF_UNITS  = DEF_OFF_UNITS,
  parameter int unsigned ZERO_UNITS = DEF_ZERO_UNITS,
  parameter int unsigned DIGIT_GAP  = DEF_DIGIT_GAP,
  parameter int unsigned WORD_GAP   = DEF_WORD_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  output logic               led,
  output logic               busy,
  output logic [3:0]         digit_out,
  output logic               digit_strobe
);

  localparam logic [31:0] ON_CYC   = unit_cycles(ON_UNITS, TICK_DIV);
  localparam logic [31:0] OFF_CYC  = unit_cycles(OFF_UNITS, TICK_DIV);
  localparam logic [31:0] ZERO_CYC = unit_cycles(ZERO_UNITS, TICK_DIV);
  localparam logic [31:0] DGAP_CYC = unit_cycles(DIGIT_GAP, TICK_DIV);
  localparam logic [31:0] WGAP_CYC = unit_cycles(WORD_GAP, TICK_DIV);

  blink_state_t     state_q, state_n;
  logic [31:0]      timer_q, timer_n;
  logic [2:0]       dig_idx_q, dig_idx_n;
  logic [3:0]       pulse_cnt_q, pulse_cnt_n;
  logic             sel_q, sel_n;
  logic             led_n;
  logic [3:0]       digit_out_n;
  logic             strobe_n;
  logic             conv_start;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [2:0]       ent_idx;
  logic [3:0]       ent_digit;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (conv_start),
    .value (in_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_n     = state_q;
    timer_n     = timer_q;
    dig_idx_n   = dig_idx_q;
    pulse_cnt_n = pulse_cnt_q;
    sel_n       = sel_q;
    led_n       = led;
    digit_out_n = digit_out;
    strobe_n    = 1'b0;
    conv_start  = 1'b0;

    // Both ways into a digit's first pulse share this: after selection, or after a digit gap.
    ent_idx   = (state_q == GAP_DIGIT) ? dig_idx_q - 3'd1 : dig_idx_q;
    ent_digit = bcd_digit(bcd, ent_idx);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          conv_start = 1'b1;
          sel_n      = 1'b0;
          state_n    = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_done) begin
          dig_idx_n = msd_index(bcd);
          sel_n     = 1'b1;
        end
      end
      PULSE_ON: begin
        if (timer_q == 32'd1) begin
          state_n     = PULSE_OFF;
          led_n       = 1'b0;
          timer_n     = OFF_CYC;
          pulse_cnt_n = pulse_cnt_q - 4'd1;
        end else begin
          timer_n = timer_q - 32'd1;
        end
      end
      PULSE_OFF: begin
        if (timer_q == 32'd1) begin
          if (pulse_cnt_q != 4'd0) begin
            state_n = PULSE_ON;
            led_n   = 1'b1;
            timer_n = ON_CYC;
          end else if (dig_idx_q != 3'd0) begin
            state_n = GAP_DIGIT;
            timer_n = DGAP_CYC;
          end else begin
            state_n = GAP_WORD;
            timer_n = WGAP_CYC;
          end
        end else begin
          timer_n = timer_q - 32'd1;
        end
      end
      GAP_DIGIT: begin
        if (timer_q != 32'd1) timer_n = timer_q - 32'd1;
      end
      GAP_WORD: begin
        if (timer_q == 32'd1) begin
          state_n     = IDLE;
          digit_out_n = '0;
          timer_n     = '0;
        end else begin
          timer_n = timer_q - 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if ((state_q == CONVERT && sel_q) || (state_q == GAP_DIGIT && timer_q == 32'd1)) begin
      state_n     = PULSE_ON;
      dig_idx_n   = ent_idx;
      digit_out_n = ent_digit;
      strobe_n    = 1'b1;
      led_n       = 1'b1;
      pulse_cnt_n = (ent_digit == 4'd0) ? 4'd1 : ent_digit;
      timer_n     = (ent_digit == 4'd0) ? ZERO_CYC : ON_CYC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      dig_idx_q    <= '0;
      pulse_cnt_q  <= '0;
      sel_q        <= 1'b0;
      led          <= 1'b0;
      digit_out    <= '0;
      digit_strobe <= 1'b0;
    end else begin
      // Strobe stays a single-cycle pulse even if ena drops right after it.
      digit_strobe <= ena & strobe_n;
      if (ena) begin
        state_q     <= state_n;
        timer_q     <= timer_n;
        dig_idx_q   <= dig_idx_n;
        pulse_cnt_q <= pulse_cnt_n;
        sel_q       <= sel_n;
        led         <= led_n;
        digit_out   <= digit_out_n;
      end
    end
  end

endmodule

// File: tb/tb_seq_digit_blinker.sv
// Scoreboard bench for seq_digit_blinker with TICK_DIV=4 and default units.
// Stimulus pushes expected pulse/word records; a negedge monitor measures and compares.
module tb_seq_digit_blinker;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 4;
  localparam int ZERO_C = 12;
  localparam int DGAP_C = 12;
  localparam int WGAP_C = 28;
  localparam int LAT_C  = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_value = '0;
  logic        in_ready, led, busy, digit_strobe;
  logic [3:0]  digit_out;

  seq_digit_blinker #(
    .TICK_DIV   (4),
    .ON_UNITS   (1),
    .OFF_UNITS  (1),
    .ZERO_UNITS (3),
    .DIGIT_GAP  (3),
    .WORD_GAP   (7)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .led          (led),
    .busy         (busy),
    .digit_out    (digit_out),
    .digit_strobe (digit_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {int d; int on_len; int off_len; int strobe;} pulse_t;
  typedef struct {int busy_len; int lat; int idle_digit;} word_t;

  pulse_t pulse_q[$];
  word_t  word_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected pulses from the decimal digits of v; ext cycles are added to pulse ext_idx.
  task automatic push_word(input int v, input int busy_exp, input int ext_idx, input int ext);
    int dig[5];
    int tmp, nd, np, k;
    pulse_t p;
    word_t w;
    tmp = v;
    for (int i = 0; i < 5; i++) begin
      dig[i] = tmp % 10;
      tmp = tmp / 10;
    end
    nd = 1;
    for (int i = 0; i < 5; i++) if (dig[i] != 0) nd = i + 1;
    k = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      np = (dig[i] == 0) ? 1 : dig[i];
      for (int j = 0; j < np; j++) begin
        p.d       = dig[i];
        p.on_len  = ((dig[i] == 0) ? ZERO_C : ON_C) + ((k == ext_idx) ? ext : 0);
        p.off_len = OFF_C + ((j < np - 1) ? 0 : ((i > 0) ? DGAP_C : WGAP_C));
        p.strobe  = (j == 0) ? 1 : 0;
        pulse_q.push_back(p);
        k++;
      end
    end
    w.busy_len   = busy_exp;
    w.lat        = LAT_C;
    w.idle_digit = 0;
    word_q.push_back(w);
  endtask

  task automatic emit_pulse(input pulse_t a);
    pulse_t e;
    n_vec++;
    if (pulse_q.size() == 0) begin
      n_fail++;
      $display("FAIL pulse_extra: got d=%0d on=%0d off=%0d stb=%0d, want no pulse",
               a.d, a.on_len, a.off_len, a.strobe);
    end else begin
      e = pulse_q.pop_front();
      if (a.d != e.d || a.on_len != e.on_len || a.off_len != e.off_len || a.strobe != e.strobe) begin
        n_fail++;
        $display("FAIL pulse: got d=%0d on=%0d off=%0d stb=%0d, want d=%0d on=%0d off=%0d stb=%0d",
                 a.d, a.on_len, a.off_len, a.strobe, e.d, e.on_len, e.off_len, e.strobe);
      end
    end
  endtask

  task automatic emit_word(input word_t a);
    word_t e;
    n_vec++;
    if (word_q.size() == 0) begin
      n_fail++;
      $display("FAIL word_extra: got busy=%0d lat=%0d, want no word", a.busy_len, a.lat);
    end else begin
      e = word_q.pop_front();
      if (a.busy_len != e.busy_len || a.lat != e.lat || a.idle_digit != e.idle_digit) begin
        n_fail++;
        $display("FAIL word: got busy=%0d lat=%0d idle_digit=%0d, want busy=%0d lat=%0d idle_digit=%0d",
                 a.busy_len, a.lat, a.idle_digit, e.busy_len, e.lat, e.idle_digit);
      end
    end
  endtask

  // Monitor: measures every LED pulse and every busy period at the negedge.
  initial begin
    pulse_t cur;
    word_t  wr;
    int prev_led, prev_busy, pend, seen, pre, blen;
    prev_led = 0; prev_busy = 0; pend = 0; seen = 0; pre = 0; blen = 0;
    cur = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_led = 0; prev_busy = 0; pend = 0; seen = 0; pre = 0; blen = 0;
      end else begin
        if (led && !prev_led) begin
          if (pend != 0) emit_pulse(cur);
          pend = 1;
          cur.d = int'(digit_out);
          cur.strobe = int'(digit_strobe);
          cur.on_len = 0;
          cur.off_len = 0;
          if (seen == 0) seen = 1;
        end else if (digit_strobe) begin
          n_vec++;
          n_fail++;
          $display("FAIL stray_strobe: got 1 outside a digit start, want 0");
        end
        if (busy) blen++;
        if (busy && seen == 0 && !led) pre++;
        if (led) cur.on_len++;
        else if (busy && pend != 0) cur.off_len++;
        if (!busy && prev_busy != 0) begin
          if (pend != 0) emit_pulse(cur);
          wr.busy_len = blen;
          wr.lat = pre;
          wr.idle_digit = int'(digit_out);
          emit_word(wr);
          pend = 0; seen = 0; pre = 0; blen = 0;
        end
        prev_led = int'(led);
        prev_busy = int'(busy);
      end
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 16'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while ((busy || pulse_q.size() != 0 || word_q.size() != 0) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check({name, "_complete"}, int'(i < 1000), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rises, prev;

    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_digit", int'(digit_out), 0);
    check("rst_strobe", int'(digit_strobe), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ena low in IDLE: offered value must not be taken.
    ena = 1'b0;
    in_valid = 1'b1;
    in_value = 16'd9;
    repeat (5) @(negedge clk);
    check("ena_idle_busy", int'(busy), 0);
    check("ena_idle_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    // Reset in the middle of the first pulse of 7.
    send(7);
    repeat (19) @(negedge clk);
    check("pre_reset_led", int'(led), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    push_word(2, 62, -1, 0);
    send(2);
    wait_done("v2");

    push_word(0, 62, -1, 0);
    send(0);
    wait_done("v0");

    push_word(305, 150, -1, 0);
    send(305);
    wait_done("v305");

    push_word(65535, 286, -1, 0);
    send(65535);
    wait_done("v65535");

    push_word(1000, 138, -1, 0);
    send(1000);
    wait_done("v1000");

    // in_valid held: 12 then 13 offered continuously.
    push_word(12, 82, -1, 0);
    push_word(13, 90, -1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 16'd12;
    @(negedge clk);
    in_value = 16'd13;
    check("held_busy", int'(busy), 1);
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    check("held_idle_gap", int'(busy), 0);
    check("held_idle_ready", int'(in_ready), 1);
    @(negedge clk);
    check("held_accept_13", int'(busy), 1);
    in_valid = 1'b0;
    wait_done("held");

    // Freeze for 50 cycles during the second pulse of 3.
    push_word(3, 120, 1, 50);
    send(3);
    rises = 0;
    prev = 0;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge clk);
      if (led && prev == 0) rises++;
      prev = int'(led);
    end
    check("ena_second_rise", rises, 2);
    ena = 1'b0;
    repeat (25) @(negedge clk);
    check("freeze_led", int'(led), 1);
    check("freeze_digit", int'(digit_out), 3);
    repeat (25) @(negedge clk);
    ena = 1'b1;
    wait_done("freeze");

    check("pulse_q_empty", pulse_q.size(), 0);
    check("word_q_empty", word_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
